fwd_bypass_net: RTL and testbench
=================================

Name: fwd_bypass_net

Overview:
- Parametrised successor to the fixed 4-way forwarding selects.
- Holds a STAGES-deep shift pipeline of in-flight register writes (dest addr, ready flag, data), advancing with the core pipeline.
- For each of NUM_RD operand read ports, resolves the youngest matching producer: forwards its data, falls back to GPR, or requests a stall when the producer's data is not yet ready (load-use, MUL, CP0).
- The oldest stage drives the register-file writeback.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register address width; address 0 is hardwired zero and never forwarded.
- STAGES, 3, in-flight stages tracked (0 = EX, 1 = MEM1, 2 = MEM2); range 1..8.
- NUM_RD, 2, operand read ports (rs, rt); range 1..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- adv  in  1  pipeline advance; all entries shift one stage toward the oldest stage.
- iss_valid  in  1  a new producer enters stage 0 on adv.
- iss_addr  in  ADDR_W  destination register of the new producer.
- iss_rdy  in  1  the new producer's data is already known at issue.
- iss_data  in  DATA_W  data of the new producer, valid when iss_rdy=1.
- res_we  in  STAGES  per-stage late-result strobe; sets ready on that stage's entry.
- res_data  in  STAGES*DATA_W  per-stage late-result data; stage s occupies bits [s*DATA_W +: DATA_W].
- flush_mask  in  STAGES  a 1 invalidates the entry in that stage this cycle.
- rd_addr  in  NUM_RD*ADDR_W  operand addresses.
- gpr_data  in  NUM_RD*DATA_W  register-file read data.
- rd_data  out  NUM_RD*DATA_W  resolved operands.
- rd_sel  out  NUM_RD*4  per port: 0 = GPR, s+1 = forwarded from stage s.
- stall  out  1  OR over ports of "matching producer not ready".
- wb_valid  out  1  oldest entry retires this cycle.
- wb_addr  out  ADDR_W  destination of the retiring entry.
- wb_data  out  DATA_W  data of the retiring entry.

Behaviour:
- Reset (rst_n=0 at a clk edge): all entries valid=0, ready=0, addr=0, data=0.
  - Outputs after reset: stall=0, wb_valid=0, rd_sel=0, rd_data=gpr_data.
  - Reset wins over every other input in that cycle.
- Entry update order within one clock edge:
  1. Apply res_we to the current stage contents: data<=res_data[s], ready<=1.
  2. If adv: stage s+1 <= updated stage s; stage 0 <= {iss_valid && iss_addr!=0, iss_addr, iss_rdy, iss_data}.
  3. Apply flush_mask to the post-shift positions: the bit indexes the stage the entry occupies after the edge.
- A late result and adv in the same cycle: the data travels with its entry.
- When adv=0, entries hold and res_we still applies.
- res_we on an invalid entry is ignored; the valid bit is unchanged.
- Lookup is combinational from registered state:
  - For each port, scan stages 0..STAGES-1 and pick the lowest-index (youngest) valid entry whose addr equals rd_addr and rd_addr!=0.
  - Match and ready: rd_data = entry data, rd_sel = s+1.
  - Match and not ready: rd_data = gpr_data, rd_sel = 0, port stall=1. An older ready match is never used past a younger pending one.
  - No match: gpr_data, rd_sel = 0.
- Same-cycle res_we is not visible to lookup; it is visible from the next cycle.
- Writeback:
  - wb_valid = adv && valid[STAGES-1] && ready[STAGES-1].
  - A valid, not-ready oldest entry with adv=1 is a protocol error; it is covered by an assertion and the entry is dropped.
- wb_addr and wb_data are driven from the oldest stage.
- STAGES=1: stage 0 is also the retiring stage.

Optional Feature:
- FWD_PERF_CNT_EN defined:
  - Adds output stall_cnt (32 bits) and input cnt_clr.
  - The counter increments each cycle stall=1 and saturates at 0xFFFFFFFF.
  - cnt_clr or reset forces it to 0; cnt_clr wins over increment.
- FWD_PERF_CNT_EN undefined: no counter logic and no such ports.

Decomposition:
- Shared package fwd_pkg:
  - RSEL_GPR = 0 constant.
  - Entry struct typedef {valid, ready, addr, data}, parametrised by width via localparams.
  - Function stage_to_sel(s) = s+1.
- One sub-module, fwd_lookup: a single-port priority matcher, instantiated NUM_RD times.

Test Plan:
- Reset, then read rs=5 with gpr=0x11 -> rd_data=0x11, rd_sel=0, stall=0; all outputs zero/idle during reset.
- Issue addr=5, rdy=1, data=0xAAAA with adv; next cycle read rs=5 -> rd_data=0xAAAA, rd_sel=1. After two more adv -> wb_valid=1, wb_addr=5, wb_data=0xAAAA.
- Load-use:
  - Issue addr=7 with rdy=0; read 7 -> stall=1.
  - res_we[1] with 0x1234 while adv=1 -> next cycle entry is at stage 2 with ready=1, rd_sel=3, rd_data=0x1234, stall=0.
- Two producers to addr=9: older 0x1 at stage 1, younger 0x2 at stage 0 -> rd_data=0x2, rd_sel=1. Younger not ready -> stall=1 even though the older one is ready.
- Register 0 never forwarded: issue addr=0 data=0xFF, read addr 0 -> rd_sel=0 and wb_valid stays 0.
- flush_mask=3'b011 with adv -> stages 0–1 invalid next cycle and no forwarding from them; a synchronous reset mid-stream clears all entries and stall in the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand forwarding / bypass network.
// Build option: FWD_PERF_CNT_EN (see fwd_bypass_net) adds a stall counter.
package fwd_pkg;

  localparam int FWD_DATA_W = 32;
  localparam int FWD_ADDR_W = 5;
  localparam int SEL_W      = 4;

  // rd_sel code meaning "operand comes from the register file"
  localparam logic [SEL_W-1:0] RSEL_GPR = '0;

  // One in-flight register write at the default core widths
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [FWD_ADDR_W-1:0] addr;
    logic [FWD_DATA_W-1:0] data;
  } fwd_entry_t;

  // rd_sel code for an operand forwarded from stage s
  function automatic logic [SEL_W-1:0] stage_to_sel(input int s);
    return SEL_W'(s + 1);
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Single read-port priority matcher: youngest matching in-flight producer wins.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W = FWD_DATA_W,
  parameter int ADDR_W = FWD_ADDR_W,
  parameter int STAGES = 3
) (
  input  logic [STAGES-1:0]        valid,
  input  logic [STAGES-1:0]        ready,
  input  logic [STAGES*ADDR_W-1:0] addr,
  input  logic [STAGES*DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        gpr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [SEL_W-1:0]         rd_sel,
  output logic                     pend
);

  // Walk oldest to youngest so the youngest match overwrites; a pending young match hides older ones
  always_comb begin
    rd_data = gpr_data;
    rd_sel  = RSEL_GPR;
    pend    = 1'b0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (valid[s] && (rd_addr != '0) && (addr[s*ADDR_W +: ADDR_W] == rd_addr)) begin
        if (ready[s]) begin
          rd_data = data[s*DATA_W +: DATA_W];
          rd_sel  = stage_to_sel(s);
          pend    = 1'b0;
        end else begin
          rd_data = gpr_data;
          rd_sel  = RSEL_GPR;
          pend    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_net.sv
// Parametrised forwarding network: tracks STAGES in-flight register writes,
// resolves NUM_RD operand ports and retires the oldest stage to the GPR file.
// Build option: FWD_PERF_CNT_EN adds cnt_clr input and a saturating stall_cnt output.
module fwd_bypass_net
  import fwd_pkg::*;
#(
  parameter int DATA_W = FWD_DATA_W,
  parameter int ADDR_W = FWD_ADDR_W,
  parameter int STAGES = 3,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adv,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     iss_rdy,
  input  logic [DATA_W-1:0]        iss_data,
  input  logic [STAGES-1:0]        res_we,
  input  logic [STAGES*DATA_W-1:0] res_data,
  input  logic [STAGES-1:0]        flush_mask,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] gpr_data,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic                     stall,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data
`ifdef FWD_PERF_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [31:0]              stall_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t ent_q   [STAGES];
  entry_t ent_res [STAGES];
  entry_t ent_nxt [STAGES];

  logic [STAGES-1:0]        valid_vec;
  logic [STAGES-1:0]        ready_vec;
  logic [STAGES*ADDR_W-1:0] addr_vec;
  logic [STAGES*DATA_W-1:0] data_vec;
  logic [NUM_RD-1:0]        port_stall;

  // Next entry state: late results first, then the shift, then flushes on post-shift positions
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      ent_res[s] = ent_q[s];
      if (res_we[s] && ent_q[s].valid) begin
        ent_res[s].ready = 1'b1;
        ent_res[s].data  = res_data[s*DATA_W +: DATA_W];
      end
    end
    for (int s = 0; s < STAGES; s++) begin
      ent_nxt[s] = ent_res[s];
    end
    if (adv) begin
      for (int s = 1; s < STAGES; s++) begin
        ent_nxt[s] = ent_res[s-1];
      end
      ent_nxt[0].valid = iss_valid && (iss_addr != '0);
      ent_nxt[0].ready = iss_rdy;
      ent_nxt[0].addr  = iss_addr;
      ent_nxt[0].data  = iss_data;
    end
    for (int s = 0; s < STAGES; s++) begin
      if (flush_mask[s]) begin
        ent_nxt[s].valid = 1'b0;
      end
    end
  end

  // Entry pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        ent_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        ent_q[s] <= ent_nxt[s];
      end
    end
  end

  // Flatten registered entries for the per-port matchers
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    addr_vec  = '0;
    data_vec  = '0;
    for (int s = 0; s < STAGES; s++) begin
      valid_vec[s]                  = ent_q[s].valid;
      ready_vec[s]                  = ent_q[s].ready;
      addr_vec[s*ADDR_W +: ADDR_W]  = ent_q[s].addr;
      data_vec[s*DATA_W +: DATA_W]  = ent_q[s].data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_lookup #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .STAGES (STAGES)
    ) u_lookup (
      .valid    (valid_vec),
      .ready    (ready_vec),
      .addr     (addr_vec),
      .data     (data_vec),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .gpr_data (gpr_data[p*DATA_W +: DATA_W]),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_sel   (rd_sel[p*SEL_W +: SEL_W]),
      .pend     (port_stall[p])
    );
  end

  assign stall    = |port_stall;
  assign wb_valid = adv && ent_q[STAGES-1].valid && ent_q[STAGES-1].ready;
  assign wb_addr  = ent_q[STAGES-1].addr;
  assign wb_data  = ent_q[STAGES-1].data;

  // Advancing a producer whose data never arrived silently loses a register write
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(adv && ent_q[STAGES-1].valid && !ent_q[STAGES-1].ready));
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating count of stalled cycles; clear has priority over counting
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_bypass_net.sv
// Self-checking bench for fwd_bypass_net: per-cycle model comparison plus
// hand-computed literal checks along a directed scenario.
// Build option: FWD_PERF_CNT_EN also checks the stall counter.
module tb_fwd_bypass_net;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int NUM_RD = 2;
  localparam int SEL_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     adv;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_rdy;
  logic [DATA_W-1:0]        iss_data;
  logic [STAGES-1:0]        res_we;
  logic [STAGES*DATA_W-1:0] res_data;
  logic [STAGES-1:0]        flush_mask;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] gpr_data;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD*SEL_W-1:0]  rd_sel;
  logic                     stall;
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
`ifdef FWD_PERF_CNT_EN
  logic                     cnt_clr;
  logic [31:0]              stall_cnt;
  logic [31:0]              m_cnt;
`endif

  int check_count = 0;
  int error_count = 0;
  bit check_en    = 1'b0;

  fwd_bypass_net #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .STAGES (STAGES),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (adv),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_rdy    (iss_rdy),
    .iss_data   (iss_data),
    .res_we     (res_we),
    .res_data   (res_data),
    .flush_mask (flush_mask),
    .rd_addr    (rd_addr),
    .gpr_data   (gpr_data),
    .rd_data    (rd_data),
    .rd_sel     (rd_sel),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
`ifdef FWD_PERF_CNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural picture of the in-flight producers, index 0 = youngest
  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mentry_t;

  mentry_t m [STAGES];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic iv, input logic [ADDR_W-1:0] ia,
                               input logic ir, input logic [DATA_W-1:0] id,
                               input logic [STAGES-1:0] rw, input logic [STAGES-1:0] fm,
                               input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1);
    adv        = a;
    iss_valid  = iv;
    iss_addr   = ia;
    iss_rdy    = ir;
    iss_data   = id;
    res_we     = rw;
    flush_mask = fm;
    rd_addr    = {r1, r0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Producer lookup: the first (youngest) valid match decides the port's fate
  function automatic void model_port(input int p, output logic [DATA_W-1:0] d,
                                     output logic [SEL_W-1:0] sel, output logic pend);
    logic [ADDR_W-1:0] ra;
    ra   = rd_addr[p*ADDR_W +: ADDR_W];
    d    = gpr_data[p*DATA_W +: DATA_W];
    sel  = '0;
    pend = 1'b0;
    if (ra != 0) begin
      for (int s = 0; s < STAGES; s++) begin
        if (m[s].valid && m[s].addr == ra) begin
          if (m[s].ready) begin
            d   = m[s].data;
            sel = SEL_W'(s + 1);
          end else begin
            pend = 1'b1;
          end
          break;
        end
      end
    end
  endfunction

  function automatic logic model_stall();
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  sel;
    logic              pend;
    logic              any;
    any = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      model_port(p, d, sel, pend);
      any = any | pend;
    end
    return any;
  endfunction

  // Model update on each clock edge
  always @(posedge clk) begin : model_update
    mentry_t nxt [STAGES];
    for (int s = 0; s < STAGES; s++) begin
      nxt[s] = m[s];
      if (res_we[s] && m[s].valid) begin
        nxt[s].ready = 1'b1;
        nxt[s].data  = res_data[s*DATA_W +: DATA_W];
      end
    end
    if (adv) begin
      for (int s = STAGES - 1; s > 0; s--) nxt[s] = nxt[s-1];
      nxt[0] = '{valid: iss_valid && (iss_addr != 0), ready: iss_rdy, addr: iss_addr, data: iss_data};
    end
    for (int s = 0; s < STAGES; s++) begin
      if (flush_mask[s]) nxt[s].valid = 1'b0;
      if (!rst_n) nxt[s] = '0;
    end
`ifdef FWD_PERF_CNT_EN
    if (!rst_n || cnt_clr) m_cnt <= '0;
    else if (model_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
`endif
    for (int s = 0; s < STAGES; s++) m[s] <= nxt[s];
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (check_en) begin
      logic [DATA_W-1:0] d;
      logic [SEL_W-1:0]  sel;
      logic              pend;
      logic              exp_wb;
      for (int p = 0; p < NUM_RD; p++) begin
        model_port(p, d, sel, pend);
        checkOutput($sformatf("model rd_data[%0d]", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(d));
        checkOutput($sformatf("model rd_sel[%0d]", p), 64'(rd_sel[p*SEL_W +: SEL_W]), 64'(sel));
      end
      checkOutput("model stall", 64'(stall), 64'(model_stall()));
      exp_wb = adv && m[STAGES-1].valid && m[STAGES-1].ready;
      checkOutput("model wb_valid", 64'(wb_valid), 64'(exp_wb));
      if (exp_wb) begin
        checkOutput("model wb_addr", 64'(wb_addr), 64'(m[STAGES-1].addr));
        checkOutput("model wb_data", 64'(wb_data), 64'(m[STAGES-1].data));
      end
`ifdef FWD_PERF_CNT_EN
      checkOutput("model stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
    end
  end

  initial begin
    rst_n    = 1'b0;
    gpr_data = {32'h0000_0022, 32'h0000_0011};
    res_data = '0;
`ifdef FWD_PERF_CNT_EN
    cnt_clr  = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    tick();
    check_en = 1'b1;
    tick();
    checkOutput("reset stall", 64'(stall), 64'd0);
    checkOutput("reset wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("reset rd_sel", 64'(rd_sel), 64'd0);
    checkOutput("reset rd_data0", 64'(rd_data[31:0]), 64'h11);
    rst_n = 1'b1;

    // Ready producer forwarded from stage 0, then retired from stage 2
    applyStimulus(1, 1, 5, 1, 32'hAAAA, 0, 0, 5, 0);
    checkOutput("empty rd_sel0", 64'(rd_sel[3:0]), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("fwd s0 rd_data0", 64'(rd_data[31:0]), 64'hAAAA);
    checkOutput("fwd s0 rd_sel0", 64'(rd_sel[3:0]), 64'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 0);
    tick();
    tick();
    checkOutput("retire wb_valid", 64'(wb_valid), 64'd1);
    checkOutput("retire wb_addr", 64'(wb_addr), 64'd5);
    checkOutput("retire wb_data", 64'(wb_data), 64'hAAAA);
    checkOutput("retire rd_sel0", 64'(rd_sel[3:0]), 64'd3);
    tick();

    // Load-use: late result arrives while advancing and travels with its entry
    applyStimulus(1, 1, 7, 0, 0, 0, 0, 7, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("load-use stall", 64'(stall), 64'd1);
    checkOutput("load-use rd_data0", 64'(rd_data[31:0]), 64'h11);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 7, 0);
    tick();
    res_data[1*DATA_W +: DATA_W] = 32'h1234;
    applyStimulus(1, 0, 0, 0, 0, 3'b010, 0, 7, 0);
    checkOutput("same-cycle res stall", 64'(stall), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("late res rd_sel0", 64'(rd_sel[3:0]), 64'd3);
    checkOutput("late res rd_data0", 64'(rd_data[31:0]), 64'h1234);
    checkOutput("late res stall", 64'(stall), 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 7, 0);
    tick();

    // Two producers of r9: youngest wins, and a pending youngest blocks the older one
    applyStimulus(1, 1, 9, 1, 32'h1, 0, 0, 9, 9);
    tick();
    applyStimulus(1, 1, 9, 1, 32'h2, 0, 0, 9, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
    checkOutput("youngest rd_data0", 64'(rd_data[31:0]), 64'h2);
    checkOutput("youngest rd_sel0", 64'(rd_sel[3:0]), 64'd1);
    checkOutput("youngest rd_sel1", 64'(rd_sel[7:4]), 64'd1);
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 9, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
    checkOutput("pending young stall", 64'(stall), 64'd1);
    checkOutput("pending young rd_sel0", 64'(rd_sel[3:0]), 64'd0);

    // Flush stages 0 and 1 after the shift; only stage 2 can forward
    applyStimulus(1, 1, 9, 1, 32'h3, 0, 3'b011, 9, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9);
    checkOutput("flush rd_sel0", 64'(rd_sel[3:0]), 64'd3);
    checkOutput("flush rd_data0", 64'(rd_data[31:0]), 64'h2);
    checkOutput("flush stall", 64'(stall), 64'd0);

    // Register 0 is never tracked, forwarded or written back
    applyStimulus(1, 1, 0, 1, 32'hFF, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0 rd_sel", 64'(rd_sel), 64'd0);
    checkOutput("r0 rd_data0", 64'(rd_data[31:0]), 64'h11);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("r0 wb_valid", 64'(wb_valid), 64'd0);

    // Hold with adv=0: a late result still lands on the held entry
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 3, 0);
    tick();
    res_data = {32'hDEAD, 32'hDEAD, 32'h55};
    applyStimulus(0, 0, 0, 0, 0, 3'b011, 0, 3, 0);
    checkOutput("hold stall", 64'(stall), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("hold rd_sel0", 64'(rd_sel[3:0]), 64'd1);
    checkOutput("hold rd_data0", 64'(rd_data[31:0]), 64'h55);

    // Synchronous reset mid-stream clears every entry
    applyStimulus(1, 1, 12, 0, 0, 0, 0, 12, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12, 3);
    checkOutput("pre-reset stall", 64'(stall), 64'd1);
    checkOutput("pre-reset rd_sel1", 64'(rd_sel[7:4]), 64'd2);
    rst_n = 1'b0;
    applyStimulus(1, 1, 14, 1, 32'h77, 3'b111, 0, 12, 3);
    tick();
    checkOutput("mid reset stall", 64'(stall), 64'd0);
    checkOutput("mid reset rd_sel", 64'(rd_sel), 64'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12, 14);
    checkOutput("post reset rd_sel", 64'(rd_sel), 64'd0);
    checkOutput("post reset rd_data1", 64'(rd_data[63:32]), 64'h22);
    tick();
    tick();

    check_en = 1'b0;
    $display("[TB] Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
